// File: rtl/rc_err_stats.sv
// Error-statistics collector for approximate ripple-carry adders: recomputes the exact sum,
// forms |error| and its square, and accumulates count/ER/ΣED/ΣED²/max over a sample window.
module rc_err_stats #(
    parameter int WIDTH    = 16,
    parameter int CNT_W    = 32,
    parameter int ED_ACC_W = 48,
    parameter int SQ_ACC_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_samples,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    input  logic [WIDTH:0]      approx_sum,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    sample_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [ED_ACC_W-1:0] sum_ed,
    output logic [SQ_ACC_W-1:0] sum_sq,
    output logic [WIDTH:0]      max_ed,
    output logic                sat
);
    localparam int QW = 2*WIDTH+2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Saturating adders: result MSB flags overflow, low bits hold the clamped sum.
    function automatic logic [CNT_W:0] sat_add_cnt(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {1'b1, {CNT_W{1'b1}}} : s;
    endfunction

    function automatic logic [ED_ACC_W:0] sat_add_ed(input logic [ED_ACC_W-1:0] a, input logic [ED_ACC_W-1:0] b);
        logic [ED_ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ED_ACC_W] ? {1'b1, {ED_ACC_W{1'b1}}} : s;
    endfunction

    function automatic logic [SQ_ACC_W:0] sat_add_sq(input logic [SQ_ACC_W-1:0] a, input logic [SQ_ACC_W-1:0] b);
        logic [SQ_ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SQ_ACC_W] ? {1'b1, {SQ_ACC_W{1'b1}}} : s;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d, acc_q, acc_d;
    logic                done_q, done_d;
    logic                clr;
    logic                accept;

    logic                vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [WIDTH:0]      ed_p1_q, ed_p1_d, ed_p2_q, ed_p2_d;
    logic [QW-1:0]       sq_p2_q, sq_p2_d;
    logic [WIDTH:0]      exact;

    logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d;
    logic [ED_ACC_W-1:0] sum_ed_q, sum_ed_d;
    logic [SQ_ACC_W-1:0] sum_sq_q, sum_sq_d;
    logic [WIDTH:0]      max_ed_q, max_ed_d;
    logic                sat_q, sat_d;
    logic [CNT_W:0]      r_cnt, r_err;
    logic [ED_ACC_W:0]   r_ed;
    logic [SQ_ACC_W:0]   r_sq;

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = done_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    clr   = 1'b1;
                    n_d   = num_samples;
                    acc_d = '0;
                    if (num_samples == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    acc_d = acc_q + CNT_W'(1);
                    if (acc_q + CNT_W'(1) == n_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!vld_p1_q && !vld_p2_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // S1: exact sum and absolute error distance; S2: ED and ED squared.
    always_comb begin
        exact    = {1'b0, op_a} + {1'b0, op_b};
        ed_p1_d  = (exact >= approx_sum) ? (exact - approx_sum) : (approx_sum - exact);
        vld_p1_d = accept;
        ed_p2_d  = ed_p1_q;
        sq_p2_d  = QW'(ed_p1_q) * QW'(ed_p1_q);
        vld_p2_d = vld_p1_q;
    end

    // S3: saturating accumulation.
    always_comb begin
        r_cnt        = sat_add_cnt(sample_cnt_q, CNT_W'(1));
        r_err        = sat_add_cnt(err_cnt_q, {{(CNT_W-1){1'b0}}, (ed_p2_q != '0)});
        r_ed         = sat_add_ed(sum_ed_q, ED_ACC_W'(ed_p2_q));
        r_sq         = sat_add_sq(sum_sq_q, SQ_ACC_W'(sq_p2_q));
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sum_ed_d     = sum_ed_q;
        sum_sq_d     = sum_sq_q;
        max_ed_d     = max_ed_q;
        sat_d        = sat_q;
        if (clr) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            sum_ed_d     = '0;
            sum_sq_d     = '0;
            max_ed_d     = '0;
            sat_d        = 1'b0;
        end else if (vld_p2_q) begin
            sample_cnt_d = r_cnt[CNT_W-1:0];
            err_cnt_d    = r_err[CNT_W-1:0];
            sum_ed_d     = r_ed[ED_ACC_W-1:0];
            sum_sq_d     = r_sq[SQ_ACC_W-1:0];
            max_ed_d     = (ed_p2_q > max_ed_q) ? ed_p2_q : max_ed_q;
            sat_d        = sat_q | r_cnt[CNT_W] | r_err[CNT_W] | r_ed[ED_ACC_W] | r_sq[SQ_ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            n_q          <= '0;
            acc_q        <= '0;
            done_q       <= 1'b0;
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_ed_q     <= '0;
            sum_sq_q     <= '0;
            max_ed_q     <= '0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            acc_q        <= acc_d;
            done_q       <= done_d;
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_ed_q     <= sum_ed_d;
            sum_sq_q     <= sum_sq_d;
            max_ed_q     <= max_ed_d;
            sat_q        <= sat_d;
        end
    end

    // Pipeline data is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        ed_p1_q <= ed_p1_d;
        ed_p2_q <= ed_p2_d;
        sq_p2_q <= sq_p2_d;
    end

    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign sum_ed     = sum_ed_q;
    assign sum_sq     = sum_sq_q;
    assign max_ed     = max_ed_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_rc_err_stats.sv
// Randomized self-checking bench for rc_err_stats against a window-level statistics model.
module tb_rc_err_stats;
    localparam int WIDTH = 16, CNT_W = 32, ED_ACC_W = 48, SQ_ACC_W = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [CNT_W-1:0]    num_samples;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    op_a, op_b;
    logic [WIDTH:0]      approx_sum;
    logic                busy, done, sat;
    logic [CNT_W-1:0]    sample_cnt, err_cnt;
    logic [ED_ACC_W-1:0] sum_ed;
    logic [SQ_ACC_W-1:0] sum_sq;
    logic [WIDTH:0]      max_ed;

    rc_err_stats #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ED_ACC_W(ED_ACC_W), .SQ_ACC_W(SQ_ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
        .approx_sum(approx_sum), .busy(busy), .done(done), .sample_cnt(sample_cnt),
        .err_cnt(err_cnt), .sum_ed(sum_ed), .sum_sq(sum_sq), .max_ed(max_ed), .sat(sat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Window-level reference: totals derived directly from the accepted samples.
    longint unsigned m_cnt, m_err, m_sed, m_ssq, m_max;
    int unsigned qa[$], qb[$], qs[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        check({tag, "_sum_ed"}, 64'(sum_ed), 64'd0);
        check({tag, "_sum_sq"}, sum_sq, 64'd0);
        check({tag, "_max_ed"}, 64'(max_ed), 64'd0);
        check({tag, "_sat"}, 64'(sat), 64'd0);
    endtask

    // mode 0: back-to-back, 1: random valid, 2: valid every other cycle then held high
    task automatic run_window(input int n, input int mode);
        int acc, last, vis;
        bit fin, exp_ready, exp_done, v;
        int acc_idx[$];
        logic [WIDTH-1:0] a, b;
        logic [WIDTH:0] ex, s;
        longint unsigned ed;
        @(negedge clk);
        start = 1'b1;
        num_samples = CNT_W'(n);
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        m_cnt = 0; m_err = 0; m_sed = 0; m_ssq = 0; m_max = 0;
        acc = 0; last = -4; fin = 1'b0;
        for (int c = 0; c < 1000 && !fin; c++) begin
            exp_ready = (acc < n);
            exp_done  = (acc == n) && (c == last + 4);
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            check("done", 64'(done), 64'(exp_done));
            check("busy", 64'(busy), 64'((acc < n) || (c < last + 4)));
            vis = 0;
            foreach (acc_idx[i]) if (acc_idx[i] <= c - 3) vis++;
            check("sample_cnt_latency", 64'(sample_cnt), 64'(vis));
            if (exp_done) begin
                check("sample_cnt", 64'(sample_cnt), m_cnt);
                check("err_cnt", 64'(err_cnt), m_err);
                check("sum_ed", 64'(sum_ed), m_sed);
                check("sum_sq", sum_sq, m_ssq);
                check("max_ed", 64'(max_ed), m_max);
                check("sat", 64'(sat), 64'd0);
                fin = 1'b1;
            end else begin
                case (mode)
                    0: v = 1'b1;
                    1: v = ($urandom_range(0, 3) != 0);
                    default: v = (acc >= 2) ? 1'b1 : (c % 2 == 0);
                endcase
                if (qa.size() > 0) begin
                    a = 16'(qa[0]); b = 16'(qb[0]); s = 17'(qs[0]);
                end else begin
                    a = 16'($urandom); b = 16'($urandom);
                    ex = {1'b0, a} + {1'b0, b};
                    case ($urandom_range(0, 3))
                        0, 1: s = ex;
                        2: s = ex ^ 17'($urandom & 32'h000FF);
                        default: s = 17'($urandom);
                    endcase
                end
                in_valid = v; op_a = a; op_b = b; approx_sum = s;
                if (v && exp_ready) begin
                    ex = {1'b0, a} + {1'b0, b};
                    ed = (ex > s) ? longint'(ex - s) : longint'(s - ex);
                    m_cnt++;
                    if (ed != 0) m_err++;
                    m_sed += ed;
                    m_ssq += ed * ed;
                    if (ed > m_max) m_max = ed;
                    acc++;
                    last = c;
                    acc_idx.push_back(c);
                    if (qa.size() > 0) begin
                        void'(qa.pop_front()); void'(qb.pop_front()); void'(qs.pop_front());
                    end
                end
                @(negedge clk);
            end
        end
        if (!fin) check("window_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        check("ready_after_done", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        op_a = '0; op_b = '0; approx_sum = '0;
        repeat (3) @(negedge clk);
        check_zero("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("rst_release");

        run_window(1, 0);

        qa = '{1, 5, 3}; qb = '{1, 5, 1}; qs = '{3, 10, 7};
        run_window(3, 0);
        check("tp3_sample_cnt", 64'(sample_cnt), 64'd3);
        check("tp3_err_cnt", 64'(err_cnt), 64'd2);
        check("tp3_sum_ed", 64'(sum_ed), 64'd4);
        check("tp3_sum_sq", sum_sq, 64'd10);
        check("tp3_max_ed", 64'(max_ed), 64'd3);

        qa = '{32'hFFFF}; qb = '{32'hFFFF}; qs = '{0};
        run_window(1, 0);
        check("max_sum_sq", sum_sq, 64'h3_FFF8_0004);
        check("max_max_ed", 64'(max_ed), 64'h1FFFE);
        check("max_sum_ed", 64'(sum_ed), 64'h1FFFE);

        run_window(2, 2);
        check("toggle_sample_cnt", 64'(sample_cnt), 64'd2);

        run_window(0, 0);
        check("n0_sample_cnt", 64'(sample_cnt), 64'd0);
        run_window(1, 0);
        check("n0_restart_cnt", 64'(sample_cnt), 64'd1);

        @(negedge clk);
        start = 1'b1; num_samples = 5;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; op_a = 16'd7; op_b = 16'd9; approx_sum = 17'd3;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("mid_rst_release");
        qa = '{2}; qb = '{2}; qs = '{4};
        run_window(1, 0);
        check("post_rst_sample_cnt", 64'(sample_cnt), 64'd1);
        check("post_rst_err_cnt", 64'(err_cnt), 64'd0);
        check("post_rst_sum_ed", 64'(sum_ed), 64'd0);

        repeat (8) run_window(int'($urandom_range(1, 20)), int'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rc_err_stats.md
# rc_err_stats

Sequential error-statistics collector placed directly downstream of the 16-bit ripple-carry approximate adders. Each handshake-accepted sample carries the operand pair and the approximate sum the adder produced. The block recomputes the exact sum, forms the absolute error distance (ED) and its square, and accumulates sample count, erroneous-sample count, ΣED, ΣED² and maximum ED over a programmed sample window. Firmware and benches derive ER, MED, MSE and WCE from these totals.

## Interface
Parameters:
- WIDTH, 16, operand width; sums are WIDTH+1 bits
- CNT_W, 32, width of sample and error counters
- ED_ACC_W, 48, width of ΣED accumulator
- SQ_ACC_W, 64, width of ΣED² accumulator

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a window (ignored in RUN)
- num_samples  in  CNT_W  window length, sampled on accepted start
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- op_a  in  WIDTH  first adder operand
- op_b  in  WIDTH  second adder operand
- approx_sum  in  WIDTH+1  adder output for (op_a, op_b)
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at window completion
- sample_cnt  out  CNT_W  samples accumulated
- err_cnt  out  CNT_W  samples with ED ≠ 0
- sum_ed  out  ED_ACC_W  ΣED
- sum_sq  out  SQ_ACC_W  ΣED²
- max_ed  out  WIDTH+1  largest ED seen
- sat  out  1  sticky; an accumulator saturated this window

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: clear all accumulators, counters and sat; latch num_samples; go to RUN. If num_samples = 0, go to DONE instead and pulse done next cycle.
- RUN: in_ready = 1 while accepted < latched N. Accept = in_valid & in_ready. On the Nth accept, go to DRAIN; in_ready drops the next cycle.
- DRAIN: wait until the pipeline is empty. Then go to DONE and assert done for one cycle.
- DONE: results hold until the next start. start in RUN or DRAIN is ignored.
- Pipeline, 3 stages, one sample per cycle, no stalls:
  - S1 registers exact = op_a + op_b (WIDTH+1 bits, zero-extended) and ED = |exact − approx_sum| (WIDTH+1 bits, unsigned).
  - S2 registers ED and ED² (2·WIDTH+2 bits).
  - S3 updates accumulators:
    - sample_cnt += 1
    - err_cnt += (ED ≠ 0)
    - sum_ed += ED
    - sum_sq += ED²
    - max_ed = max(max_ed, ED)
- Saturation: any counter or accumulator that would overflow clamps to all-ones and sets sat; sat stays set until the next start.
- in_valid while in_ready = 0: sample ignored, no state change.

## Timing
- Reset (async assert, sync deassert): state IDLE. All outputs 0, including in_ready, busy, done, sat and all statistics.
- The first accept is possible the cycle after start.
- A sample accepted in cycle t appears in the statistic outputs after the edge ending cycle t+2, i.e. visible in cycle t+3.
- done asserts in the cycle after the last accumulator update. With back-to-back samples, done is high 4 cycles after the Nth accept.
- busy is high from the cycle after start through the cycle before done. busy and done are never high together.
- Reset asserted mid-window: everything returns to reset values immediately; in-flight samples are discarded.
- Throughput: 1 sample/cycle sustained.

## Test plan
- Reset: hold rst_n low, then release → all outputs 0, in_ready = 0. start with N = 1 → in_ready = 1 on the next cycle.
- N = 3, back-to-back samples (1,1,3), (5,5,10), (3,1,7) → sample_cnt = 3, err_cnt = 2, sum_ed = 4, sum_sq = 10, max_ed = 3, sat = 0; done pulses 4 cycles after the third accept, then the block sits in DONE.
- N = 1, sample (0xFFFF,0xFFFF,0x00000) → ED = 0x1FFFE, sum_sq = 0x3FFF80004, max_ed = 0x1FFFE.
- N = 2 with in_valid toggling every other cycle and a third valid sample held after the second accept → exactly 2 accepted; in_ready = 0 after the second; the third sample never counts.
- start with N = 0 → done pulses the next cycle, busy never rises, all stats 0. A following start with N = 1 restarts cleanly from zero.
- Assert rst_n low during RUN after 2 of 5 accepts → all outputs 0 and state IDLE. A new start with N = 1 and sample (2,2,4) → sample_cnt = 1, err_cnt = 0, sum_ed = 0.
